// File: rtl/dso_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dso_capture_ctrl
//  Description : Write-side capture controller for the DSO sample memory.
//                Streams ADC samples into one 2048-word bank of a 4096-word
//                dual-port buffer. It keeps PRETRIG samples ahead of the
//                trigger, detects a level/slope trigger, fills the rest of
//                the frame, publishes the oldest-sample address and then
//                swaps banks.
//                Optional macro CAPTURE_AUTOTRIG_EN adds a forced trigger
//                after AUTO_TIMEOUT valid samples in ARMED.
//  Revision    : 1.0 - initial release
// ============================================================================
module dso_capture_ctrl #(
    parameter int PRETRIG      = 1024,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    input  logic [7:0]  trig_level,
    input  logic        trig_slope,
    input  logic        force_trig,
    output logic        mem_we,
    output logic [11:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic [11:0] write_addr,
    output logic        update_flag,
    output logic        busy,
    output logic        triggered
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Frame is always 2048 words: PRETRIG before the trigger, the rest after
    // (the trigger sample itself is the first post-trigger sample).
    localparam logic [11:0] C_PRE_LEN  = 12'(PRETRIG);
    localparam logic [11:0] C_POST_LEN = 12'(2048 - PRETRIG);

    state_t      r_state;
    logic        r_bank;
    logic [10:0] r_wptr;
    logic [11:0] r_cnt;
    logic [7:0]  r_prev;

    logic        w_in_capture;
    logic        w_write;
    logic        w_rise;
    logic        w_fall;
    logic        w_auto_hit;
    logic        w_trig;
    logic [11:0] w_cnt_inc;

`ifdef CAPTURE_AUTOTRIG_EN
    localparam int                  C_AUTO_W   = (AUTO_TIMEOUT < 2) ? 1 : $clog2(AUTO_TIMEOUT + 1);
    localparam logic [C_AUTO_W-1:0] C_AUTO_LIM = C_AUTO_W'(AUTO_TIMEOUT);

    logic [C_AUTO_W-1:0] r_auto_cnt;

    assign w_auto_hit = (r_auto_cnt == C_AUTO_LIM);

    // Valid samples seen in ARMED; cleared on entry, holds once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (r_state == S_PRE && sample_valid && w_cnt_inc == C_PRE_LEN) begin
            r_auto_cnt <= '0;
        end else if (r_state == S_ARMED && sample_valid && !w_auto_hit) begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end
`else
    logic w_unused_auto;

    assign w_auto_hit    = 1'b0;
    assign w_unused_auto = (AUTO_TIMEOUT != 0);
`endif

    // Write qualification and trigger decision on the current sample
    always_comb begin
        w_in_capture = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
        w_write      = sample_valid && w_in_capture;
        w_rise       = (r_prev <  trig_level) && (sample[15:8] >= trig_level);
        w_fall       = (r_prev >= trig_level) && (sample[15:8] <  trig_level);
        w_trig       = force_trig || (trig_slope ? w_fall : w_rise) || w_auto_hit;
        w_cnt_inc    = r_cnt + 12'd1;
    end

    // Capture state machine with registered memory port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bank      <= 1'b0;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_prev      <= '0;
            mem_we      <= 1'b0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            write_addr  <= '0;
            update_flag <= 1'b0;
            busy        <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            mem_we      <= w_write;
            update_flag <= 1'b0;

            // Every accepted sample is written at the current pointer, which
            // then advances (wrapping inside the bank) and feeds slope history.
            if (w_write) begin
                mem_waddr <= {r_bank, r_wptr};
                mem_wdata <= sample;
                r_wptr    <= r_wptr + 11'd1;
                r_prev    <= sample[15:8];
            end

            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_wptr  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_PRE;
                    end
                end

                S_PRE: begin
                    if (sample_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_PRE_LEN) begin
                            r_state <= S_ARMED;
                        end
                    end
                end

                S_ARMED: begin
                    if (sample_valid && w_trig) begin
                        r_cnt <= 12'd1;
                        // With PRETRIG = 2047 the trigger sample completes the frame
                        if (C_POST_LEN == 12'd1) begin
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            triggered <= 1'b1;
                            r_state   <= S_POST;
                        end
                    end
                end

                S_POST: begin
                    if (sample_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == C_POST_LEN) begin
                            busy      <= 1'b0;
                            triggered <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Next write position is the oldest sample of the frame
                    write_addr  <= {r_bank, r_wptr};
                    update_flag <= 1'b1;
                    r_bank      <= ~r_bank;
                    r_state     <= S_IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    triggered <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dso_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dso_capture_ctrl
//  Description : Scoreboard bench for dso_capture_ctrl. Three instances with
//                PRETRIG = 1024, 1 and 2047 share one stimulus stream; a
//                reference model queues expected writes and publishes.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dso_capture_ctrl;

    localparam int C_AUTO_TO = 100;
    localparam int ST_IDLE   = 0;
    localparam int ST_PRE    = 1;
    localparam int ST_ARMED  = 2;
    localparam int ST_POST   = 3;
    localparam int ST_DONE   = 4;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic        arm          = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample       = '0;
    logic [7:0]  trig_level   = 8'd128;
    logic        trig_slope   = 1'b0;
    logic        force_trig   = 1'b0;

    logic [2:0]  we;
    logic [2:0]  upd;
    logic [2:0]  bsy;
    logic [2:0]  trg;
    logic [11:0] waddr [3];
    logic [15:0] wdata [3];
    logic [11:0] wa    [3];

    int n_err = 0;
    int n_chk = 0;

    // reference model state, one slot per instance
    int          m_state [3];
    logic        m_bank  [3];
    logic [10:0] m_wptr  [3];
    int          m_cnt   [3];
    logic [7:0]  m_prev  [3];
    int          m_auto  [3];
    logic [15:0] m_trig  [3];
    logic        m_we    [3];
    logic        m_upd   [3];
    logic [27:0] wq [3][$];
    logic [11:0] pq [3][$];

    // observed memory contents and address bookkeeping
    logic [15:0] img [3][4096];
    logic [11:0] last_addr [3];
    logic [11:0] last_pub  [3];
    logic        saw_wrap  [3];
    logic [11:0] min_addr  [3];
    int          first_trig;

    always #5 clk = ~clk;

    dso_capture_ctrl #(.PRETRIG(1024), .AUTO_TIMEOUT(C_AUTO_TO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .trig_slope(trig_slope), .force_trig(force_trig),
        .mem_we(we[0]), .mem_waddr(waddr[0]), .mem_wdata(wdata[0]), .write_addr(wa[0]),
        .update_flag(upd[0]), .busy(bsy[0]), .triggered(trg[0]));

    dso_capture_ctrl #(.PRETRIG(1), .AUTO_TIMEOUT(C_AUTO_TO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .trig_slope(trig_slope), .force_trig(force_trig),
        .mem_we(we[1]), .mem_waddr(waddr[1]), .mem_wdata(wdata[1]), .write_addr(wa[1]),
        .update_flag(upd[1]), .busy(bsy[1]), .triggered(trg[1]));

    dso_capture_ctrl #(.PRETRIG(2047), .AUTO_TIMEOUT(C_AUTO_TO)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .sample_valid(sample_valid), .sample(sample),
        .trig_level(trig_level), .trig_slope(trig_slope), .force_trig(force_trig),
        .mem_we(we[2]), .mem_waddr(waddr[2]), .mem_wdata(wdata[2]), .write_addr(wa[2]),
        .update_flag(upd[2]), .busy(bsy[2]), .triggered(trg[2]));

    task automatic chk(input string tag, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", tag, k, act, exp, $time);
        end
    endtask

    function automatic int pre(input int k);
        return (k == 0) ? 1024 : ((k == 1) ? 1 : 2047);
    endfunction

    function automatic logic all_idle();
        return (m_state[0] == ST_IDLE) && (m_state[1] == ST_IDLE) && (m_state[2] == ST_IDLE);
    endfunction

    function automatic logic [15:0] img_at(input int k, input int off);
        logic [10:0] a;
        a = last_pub[k][10:0] + 11'(off);
        return img[k][{last_pub[k][11], a}];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = ST_IDLE;
            m_bank[k]  = 1'b0;
            m_wptr[k]  = '0;
            m_cnt[k]   = 0;
            m_prev[k]  = '0;
            m_auto[k]  = 0;
            m_we[k]    = 1'b0;
            m_upd[k]   = 1'b0;
            wq[k].delete();
            pq[k].delete();
        end
    endtask

    task automatic push_wr(input int k, input logic [15:0] s);
        m_we[k] = 1'b1;
        wq[k].push_back({m_bank[k], m_wptr[k], s});
        m_wptr[k] = m_wptr[k] + 11'd1;
        m_prev[k] = s[15:8];
    endtask

    // advance instance k's model across one rising edge with the given inputs
    task automatic model_step(input int k, input logic v, input logic [15:0] s, input logic ft, input logic a);
        logic hit;
        m_we[k]  = 1'b0;
        m_upd[k] = 1'b0;
        case (m_state[k])
            ST_IDLE: if (a) begin
                m_wptr[k]  = '0;
                m_cnt[k]   = 0;
                m_state[k] = ST_PRE;
            end
            ST_PRE: if (v) begin
                push_wr(k, s);
                m_cnt[k]++;
                if (m_cnt[k] == pre(k)) begin
                    m_state[k] = ST_ARMED;
                    m_auto[k]  = 0;
                end
            end
            ST_ARMED: if (v) begin
                if (trig_slope) hit = (m_prev[k] >= trig_level) && (s[15:8] < trig_level);
                else            hit = (m_prev[k] <  trig_level) && (s[15:8] >= trig_level);
                hit = hit || ft;
`ifdef CAPTURE_AUTOTRIG_EN
                if (m_auto[k] == C_AUTO_TO) hit = 1'b1;
                else                        m_auto[k]++;
`endif
                push_wr(k, s);
                if (hit) begin
                    m_trig[k]  = s;
                    m_cnt[k]   = 1;
                    m_state[k] = (m_cnt[k] == 2048 - pre(k)) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: if (v) begin
                push_wr(k, s);
                m_cnt[k]++;
                if (m_cnt[k] == 2048 - pre(k)) m_state[k] = ST_DONE;
            end
            default: begin
                m_upd[k] = 1'b1;
                pq[k].push_back({m_bank[k], m_wptr[k]});
                m_bank[k]  = ~m_bank[k];
                m_state[k] = ST_IDLE;
            end
        endcase
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic ft, input logic a);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        force_trig   = ft;
        arm          = a;
        for (int k = 0; k < 3; k++) model_step(k, v, s, ft, a);
        @(posedge clk);
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_we"},    k, 32'(we[k]),    0);
            chk({tag, "_waddr"}, k, 32'(waddr[k]), 0);
            chk({tag, "_wdata"}, k, 32'(wdata[k]), 0);
            chk({tag, "_waddr_pub"}, k, 32'(wa[k]), 0);
            chk({tag, "_upd"},   k, 32'(upd[k]),   0);
            chk({tag, "_busy"},  k, 32'(bsy[k]),   0);
            chk({tag, "_trig"},  k, 32'(trg[k]),   0);
        end
    endtask

    // mode 0 ramp, 1 gapped square wave, 2 long ARMED then force, 3 constant
    task automatic run_frame(input int mode, input int bound);
        int          i;
        int          sc;
        logic        v;
        logic        ft;
        logic [7:0]  hi;
        sc         = 0;
        i          = 0;
        first_trig = 0;
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        while (!all_idle() && i < bound) begin
            v  = 1'b1;
            ft = 1'b0;
            case (mode)
                0:       hi = 8'(sc);
                1: begin
                    v  = ($urandom_range(3) != 0);
                    hi = (((sc / 8) % 2) != 0) ? 8'h00 : 8'h80;
                end
                2: begin
                    hi = 8'h10;
                    ft = (i == 6000);
                end
                default: begin
                    hi = 8'h10;
`ifndef CAPTURE_AUTOTRIG_EN
                    ft = (i == 2500);
`endif
                end
            endcase
            if (v) sc++;
            drive(v, {hi, 8'(sc)}, ft, 1'b0);
            #1;
            if (mode == 3 && trg[0] && first_trig == 0) first_trig = sc;
            i++;
        end
        chk("frame_complete", mode, 32'(all_idle()), 1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // compare every cycle's outputs with the model, popping queued writes/publishes
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk("mem_we", k, 32'(we[k]), 32'(m_we[k]));
                if (we[k]) begin
                    chk("write_q_depth", k, wq[k].size(), 1);
                    if (wq[k].size() > 0) begin
                        logic [27:0] e;
                        e = wq[k].pop_front();
                        chk("mem_waddr", k, 32'(waddr[k]), 32'(e[27:16]));
                        chk("mem_wdata", k, 32'(wdata[k]), 32'(e[15:0]));
                    end
                    img[k][waddr[k]] = wdata[k];
                    if (last_addr[k][10:0] == 11'h7FF && waddr[k][10:0] == 11'h000) saw_wrap[k] = 1'b1;
                    if (waddr[k] < min_addr[k]) min_addr[k] = waddr[k];
                    last_addr[k] = waddr[k];
                end
                chk("update_flag", k, 32'(upd[k]), 32'(m_upd[k]));
                if (upd[k]) begin
                    chk("pub_q_depth", k, pq[k].size(), 1);
                    if (pq[k].size() > 0) chk("write_addr", k, 32'(wa[k]), 32'(pq[k].pop_front()));
                    last_pub[k] = wa[k];
                    chk("trig_sample", k, 32'(img_at(k, pre(k))), 32'(m_trig[k]));
                end
                chk("busy", k, 32'(bsy[k]),
                    32'(m_state[k] == ST_PRE || m_state[k] == ST_ARMED || m_state[k] == ST_POST));
                chk("triggered", k, 32'(trg[k]), 32'(m_state[k] == ST_POST));
            end
        end
    end

    initial begin
        logic [15:0] w;
        int          i;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            last_addr[k] = '0;
            last_pub[k]  = '0;
            saw_wrap[k]  = 1'b0;
            min_addr[k]  = 12'hFFF;
        end
        #2 rst_n = 1'b0;
        #2 check_reset("rst_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // basic rising-edge frame on a ramp
        trig_level = 8'd128;
        trig_slope = 1'b0;
        run_frame(0, 6000);
`ifndef CAPTURE_AUTOTRIG_EN
        for (int k = 0; k < 3; k++) begin
            chk("basic_bank", k, 32'(last_pub[k][11]), 0);
            w = img_at(k, pre(k));
            chk("basic_trig_hi", k, 32'(w[15:8]), 128);
            w = img_at(k, pre(k) - 1);
            chk("basic_prev_hi", k, 32'(w[15:8]), 127);
        end
`endif

        // falling slope on a gapped square wave, now in bank 1
        for (int k = 0; k < 3; k++) min_addr[k] = 12'hFFF;
        trig_level = 8'h40;
        trig_slope = 1'b1;
        run_frame(1, 12000);
        for (int k = 0; k < 3; k++) begin
            chk("fall_bank1_only", k, 32'(min_addr[k] >= 12'h800), 1);
            w = img_at(k, pre(k));
            chk("fall_trig_hi", k, 32'(w[15:8]), 32'h00);
            w = img_at(k, pre(k) - 1);
            chk("fall_prev_hi", k, 32'(w[15:8]), 32'h80);
        end

        // long ARMED with pointer wrap, then force
        for (int k = 0; k < 3; k++) saw_wrap[k] = 1'b0;
        trig_level = 8'd128;
        trig_slope = 1'b0;
        run_frame(2, 10000);
        chk("wrap_seen", 0, 32'(saw_wrap[0]), 1);

        // reset during POST: bank was 1 before the reset
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        i = 0;
        while (!(m_state[0] == ST_POST && m_cnt[0] >= 50) && i < 4000) begin
            drive(1'b1, {8'(i), 8'h33}, 1'b0, 1'b0);
            i++;
        end
        #1 chk("post_before_rst", 0, 32'(trg[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sample_valid = 1'b0;
        #1 check_reset("rst_mid");
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 6000);
        for (int k = 0; k < 3; k++) chk("bank_after_rst", k, 32'(last_pub[k][11]), 0);

        // auto-trigger: constant sample never crosses the level
        run_frame(3, 6000);
`ifdef CAPTURE_AUTOTRIG_EN
        chk("auto_trig_sample", 0, first_trig, 1024 + C_AUTO_TO + 1);
`else
        chk("no_auto_trig", 0, first_trig, 2501);
`endif

        for (int k = 0; k < 3; k++) begin
            chk("write_q_drained", k, wq[k].size(), 0);
            chk("pub_q_drained", k, pq[k].size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
